// File: rtl/ps2_cmd_pkg.sv
// Shared scan codes, colours and types for the PS/2 frame command scheduler.
// Set-2 make codes for the arrow cluster; keypad 8/2/4/6 share them once E0 is ignored.
package ps2_cmd_pkg;

    localparam logic [7:0] KC_EXT   = 8'hE0;
    localparam logic [7:0] KC_BRK   = 8'hF0;
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;
    localparam logic [7:0] KC_SPACE = 8'h29;

    localparam logic [11:0] BG_RESET = 12'hC30;
    localparam logic [11:0] BG_UP    = 12'hF00;
    localparam logic [11:0] BG_DOWN  = 12'h0F0;
    localparam logic [11:0] BG_LEFT  = 12'h00F;
    localparam logic [11:0] BG_RIGHT = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_state_t;

    typedef struct packed {
        logic down;
        logic right;
        logic left;
        logic up;
    } dir_t;

    function automatic dir_t key_dir(input logic [7:0] kc);
        dir_t d;
        d = '0;
        case (kc)
            KC_UP:    d.up    = 1'b1;
            KC_DOWN:  d.down  = 1'b1;
            KC_LEFT:  d.left  = 1'b1;
            KC_RIGHT: d.right = 1'b1;
            default:  d = '0;
        endcase
        return d;
    endfunction

    function automatic logic is_prefix(input logic [7:0] kc);
        return (kc == KC_EXT) || (kc == KC_BRK);
    endfunction

endpackage

// File: rtl/ps2_seq_parser.sv
// PS/2 set-2 prefix parser: turns the byte stream into make/break strobes,
// with a prefix timeout and a saturating count of discarded sequences.
//
// state   | meaning
// IDLE    | no prefix pending; a plain byte is a make
// EXT     | E0 seen; expecting F0 or an extended make
// BRK     | F0 seen; expecting the code being released
// EXT_BRK | E0 F0 seen; expecting the extended code being released
module ps2_seq_parser
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic       pixel_clk,
    input  logic       CPU_RESETN,
    input  logic [7:0] keycode,
    input  logic       key_valid,
    output logic       make_stb,
    output logic       brk_stb,
    output logic [7:0] code,
    output logic [7:0] drop_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t      state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            kv_q;
    logic            byte_stb;
    logic            drop;

    assign byte_stb = key_valid & ~kv_q;
    assign code     = keycode;

    always_ff @(posedge pixel_clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state      <= IDLE;
            timer      <= '0;
            kv_q       <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            kv_q  <= key_valid;
            if (drop && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

    // A byte arriving on the timeout cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        make_stb = 1'b0;
        brk_stb  = 1'b0;
        drop     = 1'b0;
        if (byte_stb) begin
            timer_nx = '0;
            case (state)
                IDLE: begin
                    if (keycode == KC_EXT)      state_nx = EXT;
                    else if (keycode == KC_BRK) state_nx = BRK;
                    else                        make_stb = 1'b1;
                end
                EXT: begin
                    if (keycode == KC_BRK) begin
                        state_nx = EXT_BRK;
                    end else if (keycode == KC_EXT) begin
                        state_nx = IDLE;
                        drop     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        make_stb = 1'b1;
                    end
                end
                BRK, EXT_BRK: begin
                    state_nx = IDLE;
                    if (is_prefix(keycode)) drop    = 1'b1;
                    else                    brk_stb = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (timer == TC_LAST) begin
                state_nx = IDLE;
                timer_nx = '0;
                drop     = 1'b1;
            end else begin
                timer_nx = timer + TW'(1);
            end
        end else begin
            timer_nx = '0;
        end
    end

endmodule

// File: rtl/ps2_frame_cmd_scheduler.sv
// Tracks held arrow keys and the requested background colour, and republishes
// them once per frame at the falling edge of vertical sync.
module ps2_frame_cmd_scheduler
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250000,
    parameter logic [11:0] DEFAULT_BG     = 12'hC30
) (
    input  logic        pixel_clk,
    input  logic        CPU_RESETN,
    input  logic [7:0]  keycode,
    input  logic        key_valid,
    input  logic        vs_in,
    output logic [3:0]  controls,
    output logic [11:0] background,
    output logic        frame_tick,
    output logic [7:0]  drop_count
);

    logic        make_stb;
    logic        brk_stb;
    logic [7:0]  code;
    dir_t        held, held_nx;
    logic [11:0] pending_bg, pending_bg_nx;
    logic        vs_q;
    logic        fb;

    ps2_seq_parser #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_parser (
        .pixel_clk (pixel_clk),
        .CPU_RESETN(CPU_RESETN),
        .keycode   (keycode),
        .key_valid (key_valid),
        .make_stb  (make_stb),
        .brk_stb   (brk_stb),
        .code      (code),
        .drop_count(drop_count)
    );

    assign fb = vs_q & ~vs_in;

    always_comb begin
        held_nx       = held;
        pending_bg_nx = pending_bg;
        if (make_stb) begin
            held_nx = dir_t'(held | key_dir(code));
            case (code)
                KC_UP:    pending_bg_nx = BG_UP;
                KC_DOWN:  pending_bg_nx = BG_DOWN;
                KC_LEFT:  pending_bg_nx = BG_LEFT;
                KC_RIGHT: pending_bg_nx = BG_RIGHT;
                KC_SPACE: pending_bg_nx = DEFAULT_BG;
                default:  pending_bg_nx = pending_bg;
            endcase
        end
        if (brk_stb)
            held_nx = dir_t'(held & ~key_dir(code));
    end

    // The frame latch samples the pre-byte held/pending values, so a byte landing
    // on the boundary cycle shows up one frame later.
    always_ff @(posedge pixel_clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            held       <= '0;
            pending_bg <= DEFAULT_BG;
            vs_q       <= 1'b1;
            controls   <= 4'd0;
            background <= DEFAULT_BG;
            frame_tick <= 1'b0;
        end else begin
            held       <= held_nx;
            pending_bg <= pending_bg_nx;
            vs_q       <= vs_in;
            frame_tick <= fb;
            if (fb) begin
                controls   <= held;
                background <= pending_bg;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_cmd_scheduler.sv
// Bench for ps2_frame_cmd_scheduler: directed scenarios plus random byte/frame
// traffic compared against a prefix-history model of the keyboard protocol.
module tb_ps2_frame_cmd_scheduler;

    localparam int          TB_TO  = 40;
    localparam logic [11:0] DEF_BG = 12'hC30;

    logic        pixel_clk = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic        key_valid = 1'b0;
    logic        vs_in = 1'b1;
    logic [3:0]  controls;
    logic [11:0] background;
    logic        frame_tick;
    logic [7:0]  drop_count;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // model: pressed-key mask, requested colour, drops, unresolved prefix bytes
    logic [3:0]  m_ctrl;
    logic [11:0] m_bg;
    int          m_drop;
    logic [7:0]  m_pref[$];
    int          m_last;
    logic [3:0]  lat_c;
    logic [11:0] lat_bg;

    ps2_frame_cmd_scheduler #(
        .TIMEOUT_CYCLES(TB_TO),
        .DEFAULT_BG    (DEF_BG)
    ) dut (
        .pixel_clk (pixel_clk),
        .CPU_RESETN(CPU_RESETN),
        .keycode   (keycode),
        .key_valid (key_valid),
        .vs_in     (vs_in),
        .controls  (controls),
        .background(background),
        .frame_tick(frame_tick),
        .drop_count(drop_count)
    );

    always #5 pixel_clk = ~pixel_clk;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ctrl = 4'd0;
        m_bg   = DEF_BG;
        m_drop = 0;
        m_pref.delete();
        m_last = 0;
        lat_c  = 4'd0;
        lat_bg = DEF_BG;
    endtask

    task automatic m_dropit();
        if (m_drop < 255) m_drop++;
    endtask

    // An unresolved prefix is abandoned TB_TO edges after its last byte.
    task automatic m_adv(input int now);
        if (m_pref.size() != 0 && now >= m_last + TB_TO) begin
            m_dropit();
            m_pref.delete();
        end
    endtask

    task automatic m_key(input logic [7:0] b, input bit press);
        logic [3:0]  mask;
        logic [11:0] col;
        bit          has_col;
        mask = 4'd0; col = m_bg; has_col = 1'b0;
        case (b)
            8'h75: begin mask = 4'b0001; col = 12'hF00; has_col = 1'b1; end
            8'h6B: begin mask = 4'b0010; col = 12'h00F; has_col = 1'b1; end
            8'h74: begin mask = 4'b0100; col = 12'hFFF; has_col = 1'b1; end
            8'h72: begin mask = 4'b1000; col = 12'h0F0; has_col = 1'b1; end
            8'h29: begin col = DEF_BG; has_col = 1'b1; end
            default: ;
        endcase
        if (press) begin
            m_ctrl = m_ctrl | mask;
            if (has_col) m_bg = col;
        end else begin
            m_ctrl = m_ctrl & ~mask;
        end
    endtask

    task automatic m_byte(input logic [7:0] b, input int edge_no);
        bit pfx;
        pfx = (b == 8'hE0) || (b == 8'hF0);
        if (m_pref.size() == 0) begin
            if (pfx) m_pref.push_back(b);
            else     m_key(b, 1'b1);
        end else if (m_pref[m_pref.size()-1] == 8'hF0) begin
            if (pfx) m_dropit();
            else     m_key(b, 1'b0);
            m_pref.delete();
        end else if (b == 8'hF0) begin
            m_pref.push_back(b);
        end else begin
            if (b == 8'hE0) m_dropit();
            else            m_key(b, 1'b1);
            m_pref.delete();
        end
        m_last = edge_no;
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        CPU_RESETN = 1'b0;
        key_valid  = 1'b0;
        vs_in      = 1'b1;
        m_reset();
        repeat (2) @(negedge pixel_clk);
        CPU_RESETN = 1'b1;
        @(negedge pixel_clk);
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        keycode   = b;
        key_valid = 1'b1;
        m_adv(cyc);
        m_byte(b, cyc + 1);
        repeat (hold) @(negedge pixel_clk);
        key_valid = 1'b0;
        repeat (gap) @(negedge pixel_clk);
    endtask

    task automatic chk_drop(input string tag);
        m_adv(cyc);
        chk(tag, drop_count, m_drop);
    endtask

    // Frame boundary, optionally with a new byte arriving on the same edge.
    task automatic frame(input bit with_byte, input logic [7:0] b);
        chk("ctrl_midframe", controls, lat_c);
        chk("bg_midframe", background, lat_bg);
        chk("tick_idle", frame_tick, 0);
        vs_in = 1'b0;
        m_adv(cyc);
        lat_c  = m_ctrl;
        lat_bg = m_bg;
        if (with_byte) begin
            keycode   = b;
            key_valid = 1'b1;
            m_byte(b, cyc + 1);
        end
        @(negedge pixel_clk);
        key_valid = 1'b0;
        chk("frame_ctrl", controls, lat_c);
        chk("frame_bg", background, lat_bg);
        chk("frame_tick", frame_tick, 1);
        @(negedge pixel_clk);
        chk("tick_single", frame_tick, 0);
        vs_in = 1'b1;
        @(negedge pixel_clk);
    endtask

    logic [7:0] tbl[9] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h1C, 8'h5A};

    initial begin
        m_reset();
        // reset with vs_in toggling: nothing may latch
        repeat (2) begin
            @(negedge pixel_clk); vs_in = 1'b0;
            @(negedge pixel_clk); vs_in = 1'b1;
        end
        chk("rst_ctrl", controls, 0);
        chk("rst_bg", background, 12'hC30);
        chk("rst_tick", frame_tick, 0);
        chk("rst_drop", drop_count, 0);
        CPU_RESETN = 1'b1;
        @(negedge pixel_clk);

        // extended up make, then extended up break
        send(8'hE0, 1, 2); send(8'h75, 1, 2);
        frame(1'b0, 8'h00);
        chk("up_ctrl", controls, 4'b0001);
        chk("up_bg", background, 12'hF00);
        send(8'hE0, 1, 1); send(8'hF0, 1, 1); send(8'h75, 1, 2);
        frame(1'b0, 8'h00);
        chk("upbrk_ctrl", controls, 4'b0000);
        chk("upbrk_bg", background, 12'hF00);

        send(8'h6B, 2, 1); send(8'h74, 1, 3);
        frame(1'b0, 8'h00);
        chk("lr_ctrl", controls, 4'b0110);
        chk("lr_bg", background, 12'hFFF);
        send(8'h29, 1, 2);
        frame(1'b0, 8'h00);
        chk("space_bg", background, 12'hC30);

        // byte coincident with the frame boundary is deferred a frame
        do_reset();
        frame(1'b1, 8'h72);
        chk("coinc_ctrl", controls, 4'b0000);
        frame(1'b0, 8'h00);
        chk("coinc_next_ctrl", controls, 4'b1000);
        chk("coinc_next_bg", background, 12'h0F0);

        // prefix timeout
        do_reset();
        send(8'hE0, 1, TB_TO + 2);
        chk("timeout_drop", drop_count, 1);
        chk_drop("timeout_model");
        send(8'h75, 1, 2);
        frame(1'b0, 8'h00);
        chk("after_to_ctrl", controls, 4'b0001);

        // long key_valid pulse is one byte: F0 then 75 releases up without a drop
        send(8'hF0, 10, 2); send(8'h75, 1, 2);
        chk("long_kv_drop", drop_count, 1);
        frame(1'b0, 8'h00);
        chk("long_kv_ctrl", controls, 4'b0000);
        send(8'hF0, 1, 1); send(8'hF0, 1, 2);
        chk("f0f0_drop", drop_count, 2);

        // reset mid-sequence leaves no drop and no pending prefix
        send(8'hE0, 1, 1); send(8'hF0, 1, 1);
        do_reset();
        repeat (TB_TO + 5) @(negedge pixel_clk);
        chk("midseq_drop", drop_count, 0);
        send(8'h75, 1, 2);
        frame(1'b0, 8'h00);
        chk("midseq_ctrl", controls, 4'b0001);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op <= 6) begin
                send(tbl[$urandom_range(0, 8)], $urandom_range(1, 3),
                     ($urandom_range(0, 9) == 0) ? TB_TO + $urandom_range(0, 3) - 2
                                                 : $urandom_range(1, 3));
            end else if (op <= 8) begin
                frame(1'b0, 8'h00);
                chk_drop("rand_drop");
            end else if (op == 9) begin
                frame(1'b1, tbl[$urandom_range(0, 8)]);
            end else begin
                repeat (TB_TO + $urandom_range(0, 3) - 1) @(negedge pixel_clk);
                chk_drop("rand_idle_drop");
            end
        end
        frame(1'b0, 8'h00);
        chk_drop("rand_end_drop");

        // saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(8'hF0, 1, 1); send(8'hF0, 1, 1);
        end
        chk("sat_drop", drop_count, 255);
        chk_drop("sat_model");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_frame_cmd_scheduler.md
Name: ps2_frame_cmd_scheduler

Overview:
- Sits between ps2_keyboard and the per-frame consumers (char_driver controls, graphics_driver background) in the pixel_clk domain.
- Parses the PS/2 set-2 byte stream (E0 extended prefix, F0 break prefix) and tracks which arrow keys are held.
- Publishes a frame-stable command set (held-direction vector, background colour) once per frame, at the start of vertical sync.
- Replaces clocking logic from VS, so all frame-rate logic runs on one clock.

Parameters:
- TIMEOUT_CYCLES, 250000, pixel_clk cycles a prefix state may wait for its next byte (10 ms at 25 MHz).
- DEFAULT_BG, 12'hC30, background colour after reset and on space-bar make.

Ports:
- pixel_clk  in  1  sole clock.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- keycode  in  8  last byte from ps2_keyboard; valid in the cycle key_valid rises.
- key_valid  in  1  level from ps2_keyboard; a new byte is its rising edge.
- vs_in  in  1  VGA vertical sync, active low, synchronous to pixel_clk.
- controls  out  4  held keys {down,right,left,up}, frame-stable.
- background  out  12  RGB444 background colour, frame-stable.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- drop_count  out  8  saturating count of malformed or timed-out sequences.

Behaviour:
- Reset values, all asynchronous on CPU_RESETN low:
  - controls = 0, background = DEFAULT_BG, frame_tick = 0, drop_count = 0.
  - Internal held = 0, pending_bg = DEFAULT_BG, FSM = IDLE, kv_q = 0, vs_q = 1, timer = 0.
- Byte strobe: byte_stb = key_valid & ~kv_q, with kv_q registered. keycode is sampled only when byte_stb is high.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions are taken only on byte_stb:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> MAKE(byte), stay in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> drop, IDLE; other -> MAKE(byte), IDLE.
  - BRK / EXT_BRK: E0 or F0 -> drop, IDLE; other -> BREAK(byte), IDLE.
- Extended and non-extended codes are treated identically. Keypad 8/2/4/6 therefore alias the arrows.
- MAKE actions:
  - 75 (up): held[0] = 1, pending_bg = F00.
  - 72 (down): held[3] = 1, pending_bg = 0F0.
  - 6B (left): held[1] = 1, pending_bg = 00F.
  - 74 (right): held[2] = 1, pending_bg = FFF.
  - 29 (space): pending_bg = DEFAULT_BG.
  - All other codes: ignored, no drop.
- BREAK actions: clear the matching held bit. Breaks of unlisted codes are ignored.
- Timeout:
  - timer counts while FSM != IDLE and resets to 0 on every byte_stb.
  - When timer reaches TIMEOUT_CYCLES-1: FSM -> IDLE, drop.
  - timer is idle (0) in IDLE.
- drop: drop_count increments and saturates at 255.
- Frame boundary: fb = vs_q & ~vs_in, with vs_q registered.
  - On the clock edge where fb is high: controls <= held, background <= pending_bg, frame_tick <= 1.
  - Latency: vs_in falling edge to outputs is 1 clock.
  - frame_tick is high for exactly one cycle.
- Simultaneous byte_stb and fb: outputs latch the pre-byte held/pending_bg. The byte's effect appears at the next frame.
- Outputs change only on frame boundaries or reset; they never change mid-frame.
- A make followed by its break within one frame: that key is not reported, but pending_bg keeps the colour.
- Reset mid-sequence (e.g. after E0 F0): returns to IDLE with no drop counted.
- Timer width is $clog2(TIMEOUT_CYCLES).

Decomposition:
- Package ps2_cmd_pkg holds:
  - scan-code constants: KC_EXT = E0, KC_BRK = F0, KC_UP, KC_DOWN, KC_LEFT, KC_RIGHT, KC_SPACE;
  - the colour constants;
  - typedef enum logic [1:0] ps2_state_t {IDLE, EXT, BRK, EXT_BRK};
  - typedef struct dir_t {down,right,left,up}.
- One sub-module, ps2_seq_parser, contains the FSM, timer and drop counter. It emits make_stb, brk_stb and code. The top level holds the held/pending registers and the frame latch.

Test Plan:
- Reset: hold CPU_RESETN low, toggle vs_in -> controls = 0, background = C30, frame_tick = 0, drop_count = 0.
- Bytes E0 75, then a vs_in falling edge -> exactly 1 cycle later controls = 4'b0001, background = F00, frame_tick pulses once. Then E0 F0 75 and a frame -> controls = 0, background stays F00.
- Bytes 6B then 74, no breaks, then a frame -> controls = 4'b0110, background = FFF. Byte 29 then a frame -> background = C30.
- byte_stb for 72 in the same cycle as fb -> that frame's controls = 0; the next frame's controls = 4'b1000, background = 0F0.
- Byte E0 then a TIMEOUT_CYCLES gap -> drop_count = 1, FSM back in IDLE. A following 75 acts as a make. 300 drops -> drop_count = 255.
- Bytes F0 F0 -> drop_count +1. key_valid held high for 10 cycles counts as one byte only.
